// File: rtl/mr_row_sequencer_if.sv
// Row-multiplier link: the sequencer (master) issues rows and the scalar,
// the mult_MR datapath (slave) returns the product row and its overflow flag.
interface mr_row_sequencer_if #(
    parameter int ROW_W = 40
);
    logic [ROW_W-1:0] mul_row;
    logic [7:0]       mul_n;
    logic             mul_clr;
    logic [ROW_W-1:0] mul_out;
    logic             mul_ovf;

    modport master (output mul_row, mul_n, mul_clr, input mul_out, mul_ovf);
    modport slave  (input mul_row, mul_n, mul_clr, output mul_out, mul_ovf);
endinterface

// File: rtl/mr_row_sequencer.sv
// Sequences a ROWS x 5 matrix-by-scalar multiply one row per clock through mult_MR.
// Optional MR_OVF_ABORT_EN: finish early on the first captured row that overflows.
module mr_row_sequencer #(
    parameter int ROWS    = 5,
    parameter int ROW_W   = 40,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROWS*ROW_W-1:0] matrix_in,
    input  logic [7:0]            scalar_in,
    output logic                  busy,
    output logic                  done,
    output logic [ROWS*ROW_W-1:0] result,
    output logic                  ovf,
    output logic [ROWS-1:0]       ovf_row_mask,
    mr_row_sequencer_if.master    mul
);

    localparam int IW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, next_state;
    logic [ROWS*ROW_W-1:0] mat_q;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         issue_idx;
    logic [MUL_LAT:0]      vld;
    logic [IW-1:0]         pidx [MUL_LAT+1];
    logic                  accept, issue, capture, last_cap, abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // A row leaving the end of the valid pipe is the multiplier's current output.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        issue       = 1'b0;
        issue_idx   = idx;
        busy        = 1'b0;
        done        = 1'b0;
        mul.mul_clr = 1'b0;
        capture     = vld[MUL_LAT] && (state == ISSUE || state == DRAIN);
        last_cap    = capture && (pidx[MUL_LAT] == IW'(ROWS - 1));
`ifdef MR_OVF_ABORT_EN
        abort       = capture && mul.mul_ovf;
`else
        abort       = 1'b0;
`endif
        case (state)
            IDLE: begin
                mul.mul_clr = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    issue      = 1'b1;
                    issue_idx  = '0;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (last_cap || abort)      next_state = DONE;
                else if (idx == IW'(ROWS))  next_state = DRAIN;
                else                        issue      = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_cap || abort) next_state = DONE;
            end
            DONE: begin
                done        = 1'b1;
                mul.mul_clr = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row 0 is issued straight from matrix_in on the accepting edge; later rows come from the latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_q        <= '0;
            idx          <= '0;
            vld          <= '0;
            for (int i = 0; i <= MUL_LAT; i++) pidx[i] <= '0;
            result       <= '0;
            ovf          <= 1'b0;
            ovf_row_mask <= '0;
            mul.mul_row  <= '0;
            mul.mul_n    <= '0;
        end else begin
            vld[0] <= issue;
            for (int i = 1; i <= MUL_LAT; i++) begin
                vld[i]  <= vld[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (issue) begin
                pidx[0]     <= issue_idx;
                idx         <= issue_idx + 1'b1;
                mul.mul_row <= accept ? matrix_in[ROW_W-1:0]
                                      : mat_q[int'(issue_idx)*ROW_W +: ROW_W];
            end
            if (accept) begin
                mat_q        <= matrix_in;
                mul.mul_n    <= scalar_in;
                result       <= '0;
                ovf          <= 1'b0;
                ovf_row_mask <= '0;
            end
            if (capture) begin
                result[int'(pidx[MUL_LAT])*ROW_W +: ROW_W] <= mul.mul_out;
                ovf_row_mask[pidx[MUL_LAT]]                <= mul.mul_ovf;
                ovf                                        <= ovf | mul.mul_ovf;
            end
            if (abort) vld <= '0;
        end
    end

endmodule

// File: tb/tb_mr_row_sequencer.sv
// Bench for mr_row_sequencer with a behavioural mult_MR attached; expectations follow
// MR_OVF_ABORT_EN when the bench is built with it.
module tb_mr_row_sequencer;

    localparam int ROWS    = 5;
    localparam int ROW_W   = 40;
    localparam int MUL_LAT = 1;
    localparam int MW      = ROWS * ROW_W;
    localparam int PERIOD  = ROWS + MUL_LAT + 2;

    typedef struct {
        logic [MW-1:0]   res;
        logic            ovf;
        logic [ROWS-1:0] mask;
        int              lat;
    } exp_t;

    typedef struct {
        logic [MW-1:0] m;
        logic [7:0]    n;
        exp_t          e;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [MW-1:0]   matrix_in = '0;
    logic [7:0]      scalar_in = '0;
    logic            busy, done, ovf;
    logic [MW-1:0]   result;
    logic [ROWS-1:0] ovf_row_mask;
    int              checks = 0;
    int              failures = 0;

    mr_row_sequencer_if #(.ROW_W(ROW_W)) mul_bus ();

    mr_row_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .matrix_in(matrix_in), .scalar_in(scalar_in),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .ovf_row_mask(ovf_row_mask),
        .mul(mul_bus)
    );

    always #5 clk = ~clk;

    // One signed 8-bit element times n, truncated; top bit flags a result outside int8.
    function automatic logic [8:0] mul_elem(input logic [7:0] a, input logic [7:0] n);
        int pa, pn, p;
        pa = $signed(a);
        pn = $signed(n);
        p  = pa * pn;
        return {(p > 127 || p < -128), p[7:0]};
    endfunction

    function automatic logic [ROW_W:0] mult_row(input logic [ROW_W-1:0] row, input logic [7:0] n);
        logic [ROW_W:0] r;
        logic [8:0]     pe;
        r = '0;
        for (int b = 0; b < 5; b++) begin
            pe = mul_elem(row[b*8 +: 8], n);
            r[b*8 +: 8] = pe[7:0];
            r[ROW_W] = r[ROW_W] | pe[8];
        end
        return r;
    endfunction

    // Behavioural mult_MR with a single register stage.
    always @(posedge clk) begin
        if (mul_bus.mul_clr) begin
            mul_bus.mul_out <= '0;
            mul_bus.mul_ovf <= 1'b0;
        end else begin
            {mul_bus.mul_ovf, mul_bus.mul_out} <= mult_row(mul_bus.mul_row, mul_bus.mul_n);
        end
    end

    // Whole-job reference: element-wise products, per-row overflow, optional early stop.
    function automatic exp_t model(input logic [MW-1:0] m, input logic [7:0] n);
        exp_t       e;
        logic [8:0] pe;
        bit         stop;
        e.res  = '0;
        e.mask = '0;
        e.lat  = ROWS + MUL_LAT;
        stop   = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (!stop) begin
                for (int b = 0; b < 5; b++) begin
                    pe = mul_elem(m[r*ROW_W + b*8 +: 8], n);
                    e.res[r*ROW_W + b*8 +: 8] = pe[7:0];
                    if (pe[8]) e.mask[r] = 1'b1;
                end
`ifdef MR_OVF_ABORT_EN
                if (e.mask[r]) begin
                    stop  = 1'b1;
                    e.lat = r + 1 + MUL_LAT;
                end
`endif
            end
        end
        e.ovf = |e.mask;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_job(input string tag, input exp_t e, input int lat);
        check_output({tag, "_result"}, result, e.res);
        check_output({tag, "_ovf"}, MW'(ovf), MW'(e.ovf));
        check_output({tag, "_mask"}, MW'(ovf_row_mask), MW'(e.mask));
        check_output({tag, "_latency"}, MW'(lat), MW'(e.lat));
    endtask

    // Called one step after an edge with the DUT idle; returns edges from E0 to done (-1 on timeout).
    task automatic apply_stimulus(input logic [MW-1:0] m, input logic [7:0] n, output int lat);
        matrix_in = m;
        scalar_in = n;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_output("busy_after_start", MW'(busy), MW'(1));
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_job();
        @(posedge clk);
        #1;
        check_output("done_single_cycle", MW'(done), MW'(0));
    endtask

    vec_t          tbl [6];
    exp_t          e;
    int            lat, dcount, bad_busy, bad_done, bad_res;
    logic [MW-1:0] a_mat, snap;

    initial begin
        tbl[0] = '{m: {25{8'h02}}, n: 8'd3,   e: '{res: {25{8'h06}}, ovf: 1'b0, mask: 5'b00000, lat: 6}};
        tbl[1] = '{m: {25{8'h01}}, n: 8'hFF,  e: '{res: {25{8'hFF}}, ovf: 1'b0, mask: 5'b00000, lat: 6}};
        tbl[2] = '{m: {25{8'h80}}, n: 8'h01,  e: '{res: {25{8'h80}}, ovf: 1'b0, mask: 5'b00000, lat: 6}};
        tbl[3] = '{m: {25{8'h7F}}, n: 8'h00,  e: '{res: {MW{1'b0}},  ovf: 1'b0, mask: 5'b00000, lat: 6}};
`ifdef MR_OVF_ABORT_EN
        tbl[4] = '{m: {{15{8'h01}}, 32'h01010101, 8'h64, {5{8'h01}}}, n: 8'd3,
                   e: '{res: {{15{8'h00}}, 32'h03030303, 8'h2C, {5{8'h03}}}, ovf: 1'b1, mask: 5'b00010, lat: 3}};
        tbl[5] = '{m: {25{8'h80}}, n: 8'hFF,
                   e: '{res: {{20{8'h00}}, {5{8'h80}}}, ovf: 1'b1, mask: 5'b00001, lat: 2}};
`else
        tbl[4] = '{m: {{15{8'h01}}, 32'h01010101, 8'h64, {5{8'h01}}}, n: 8'd3,
                   e: '{res: {{15{8'h03}}, 32'h03030303, 8'h2C, {5{8'h03}}}, ovf: 1'b1, mask: 5'b00010, lat: 6}};
        tbl[5] = '{m: {25{8'h80}}, n: 8'hFF,
                   e: '{res: {25{8'h80}}, ovf: 1'b1, mask: 5'b11111, lat: 6}};
`endif

        #2 rst = 1'b0;
        #1;
        check_output("reset_busy", MW'(busy), MW'(0));
        check_output("reset_done", MW'(done), MW'(0));
        check_output("reset_result", result, '0);
        check_output("reset_ovf", MW'({ovf, ovf_row_mask}), MW'(0));
        check_output("reset_mul_row", MW'(mul_bus.mul_row), MW'(0));
        check_output("reset_mul_n", MW'(mul_bus.mul_n), MW'(0));
        check_output("reset_mul_clr", MW'(mul_bus.mul_clr), MW'(1));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(tbl[i].m, tbl[i].n, lat);
            check_job($sformatf("table%0d", i), tbl[i].e, lat);
            finish_job();
        end

        for (int j = 0; j < 40; j++) begin
            logic [MW-1:0] m;
            logic [7:0]    n;
            for (int b = 0; b < ROWS * 5; b++)
                m[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20) - 10);
            n = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24) - 12);
            apply_stimulus(m, n, lat);
            check_job($sformatf("rand%0d", j), model(m, n), lat);
            finish_job();
        end

        // Second start and new operands during the job must not disturb it.
        a_mat = {5{40'h01_02_03_FD_10}};
        e = model(a_mat, 8'd3);
        matrix_in = a_mat;
        scalar_in = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 matrix_in = {25{8'h7F}};
        scalar_in = 8'h40;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        lat = -1;
        snap = '0;
        for (int k = 3; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                if (lat < 0) begin
                    lat = k;
                    snap = result;
                end
            end
        end
        check_output("ignored_start_done_count", MW'(dcount), MW'(1));
        check_output("ignored_start_latency", MW'(lat), MW'(e.lat));
        check_output("ignored_start_result", snap, e.res);
        check_output("result_held", result, e.res);

        // Reset in the middle of a job.
        matrix_in = {25{8'h02}};
        scalar_in = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("midreset_busy", MW'(busy), MW'(0));
        check_output("midreset_done", MW'(done), MW'(0));
        check_output("midreset_result", result, '0);
        check_output("midreset_ovf", MW'({ovf, ovf_row_mask}), MW'(0));
        check_output("midreset_mul_row", MW'({mul_bus.mul_row, mul_bus.mul_n}), MW'(0));
        check_output("midreset_mul_clr", MW'(mul_bus.mul_clr), MW'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_output("midreset_no_done", MW'(dcount), MW'(0));
        apply_stimulus(tbl[0].m, tbl[0].n, lat);
        check_job("after_reset", tbl[0].e, lat);
        finish_job();

        // start held high: jobs repeat with one idle cycle between them.
        matrix_in = {25{8'h01}};
        scalar_in = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        bad_busy = 0;
        bad_done = 0;
        bad_res  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (busy !== !((k % PERIOD) == ROWS + MUL_LAT || (k % PERIOD) == ROWS + MUL_LAT + 1))
                bad_busy++;
            if (done !== ((k % PERIOD) == ROWS + MUL_LAT)) bad_done++;
            if (done && (result !== {25{8'hFF}} || ovf !== 1'b0)) bad_res++;
        end
        start = 1'b0;
        check_output("b2b_busy_pattern", MW'(bad_busy), MW'(0));
        check_output("b2b_done_period", MW'(bad_done), MW'(0));
        check_output("b2b_result", MW'(bad_res), MW'(0));
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
